// File: rtl/obuffer_pack.sv
// Byte-to-word collector: packs 8-bit array results MSB-first into 32-bit
// words and queues completed words in a small FIFO for the memory writer.
module obuffer_pack #(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CLR,
    input  logic [7:0]  ID,
    input  logic        IValid,
    input  logic        Flush,
    output logic [31:0] OWord,
    output logic        OValid,
    input  logic        OReady,
    output logic        Full,
    output logic        Overflow,
    output logic        Busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0] pack, pack_next, lane_word, push_word;
    logic [1:0]  cnt, cnt_next;
    logic        fp, fp_next, ovf_next;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic pop, push, room, accept, complete, flush_req;

    assign pop       = OValid & OReady;
    assign room      = (count != DEPTH_C) | pop;
    assign accept    = IValid & ~fp;
    assign complete  = accept & (cnt == 2'd3);
    assign flush_req = fp | (Flush & ((cnt != 2'd0) | accept));

    always_comb begin
        lane_word = pack;
        case (cnt)
            2'd0:    lane_word = {ID, pack[23:0]};
            2'd1:    lane_word = {pack[31:24], ID, pack[15:0]};
            2'd2:    lane_word = {pack[31:16], ID, pack[7:0]};
            default: lane_word = {pack[31:8], ID};
        endcase
    end

    // A same-cycle byte is absorbed before a flush; an overflowed lane-3 byte
    // leaves the partial word intact so a later flush can still close it.
    always_comb begin
        pack_next = pack;
        cnt_next  = cnt;
        fp_next   = fp;
        ovf_next  = Overflow;
        push      = 1'b0;
        push_word = lane_word;
        if (complete) begin
            if (room) begin
                push      = 1'b1;
                pack_next = '0;
                cnt_next  = 2'd0;
                fp_next   = 1'b0;
            end else begin
                ovf_next = 1'b1;
                fp_next  = Flush;
            end
        end else if (flush_req) begin
            if (room) begin
                push      = 1'b1;
                push_word = accept ? lane_word : pack;
                pack_next = '0;
                cnt_next  = 2'd0;
                fp_next   = 1'b0;
            end else begin
                fp_next = 1'b1;
                if (accept) begin
                    pack_next = lane_word;
                    cnt_next  = cnt + 2'd1;
                end
            end
        end else if (accept) begin
            pack_next = lane_word;
            cnt_next  = cnt + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pack     <= '0;
            cnt      <= 2'd0;
            fp       <= 1'b0;
            Overflow <= 1'b0;
        end else if (CLR) begin
            pack     <= '0;
            cnt      <= 2'd0;
            fp       <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            pack     <= pack_next;
            cnt      <= cnt_next;
            fp       <= fp_next;
            Overflow <= ovf_next;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (CLR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    assign OValid = (count != '0);
    assign Full   = (count == DEPTH_C);
    assign Busy   = (cnt != 2'd0) | (count != '0) | fp;
    assign OWord  = OValid ? mem[rd_ptr] : 32'h0;

endmodule
